lsu_mem_stage: RTL and testbench

- Memory-stage load/store unit between the pipeline's M-stage outputs (ALU address, store data, read/write strobes) and a multi-cycle data memory with a req/ack handshake.
- Generates byte enables and replicated store lanes, and extracts the load value into ReadDataM.
- Holds the whole pipeline with StallMem until the access completes.
- Flags misaligned or timed-out accesses.

---
 rtl/lsu_mem_stage_if.sv | 25 ++
 rtl/lsu_mem_stage.sv | 197 +++++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_stage_if.sv
// Data-memory bus between the load/store unit (master) and a multi-cycle
// memory (slave). The master holds mem_req and the command fields stable
// until the slave answers with a single-cycle mem_ack.
interface lsu_mem_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit. Turns the M-stage address/data/strobes into
// one req/ack bus transaction, stalls the whole pipeline until it finishes,
// aligns the load result and pulses FaultM on misalignment or timeout.
// Optional macro LSU_SIGNEXT_EN: when defined, sub-word loads with SignedM=1
// are sign-extended; otherwise every sub-word load is zero-extended.
module lsu_mem_stage #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [1:0]        SizeM,
    input  logic              SignedM,
    input  logic [ADDR_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              StallMem,
    output logic              FaultM,
    lsu_mem_stage_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic              req_reg, we_reg, fault_reg, signed_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [3:0]        be_reg;
    logic [DATA_W-1:0] wdata_reg, read_data_reg;
    logic [1:0]        offs_reg, size_reg;

    logic              op, misaligned, stall_raw, sign_en;
    logic              timed_out;
    logic [3:0]        be_next;
    logic [DATA_W-1:0] wdata_next, load_data, capture_data;
    logic [7:0]        rd_lane [4];
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;

    assign op        = MemReadM | MemWriteM;
    assign timed_out = (cnt_reg == CNT_LAST);

    // Alignment rules: byte always ok, half needs a[0]=0, word/reserved needs a[1:0]=0.
    always_comb begin
        misaligned = 1'b0;
        case (SizeM)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = ALUOutM[0];
            default: misaligned = ALUOutM[1] | ALUOutM[0];
        endcase
    end

    // Little-endian byte enables for the addressed lanes.
    always_comb begin
        be_next = 4'b1111;
        case (SizeM)
            2'b00:   be_next = 4'b0001 << ALUOutM[1:0];
            2'b01:   be_next = 4'b0011 << ALUOutM[1:0];
            default: be_next = 4'b1111;
        endcase
    end

    // Store data is replicated so whichever lanes are enabled carry the value;
    // read lanes are split out for the load extractor.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign wdata_next[8*gi +: 8] =
            (SizeM == 2'b00) ? WriteDataM[7:0] :
            (SizeM == 2'b01) ? WriteDataM[8*(gi%2) +: 8] :
                               WriteDataM[8*gi +: 8];
        assign rd_lane[gi] = bus.mem_rdata[8*gi +: 8];
    end

`ifdef LSU_SIGNEXT_EN
    assign sign_en = signed_reg;
`else
    // SignedM is accepted but has no effect in this build.
    assign sign_en = signed_reg & 1'b0;
`endif

    assign rd_byte = rd_lane[offs_reg];
    assign rd_half = offs_reg[1] ? {rd_lane[3], rd_lane[2]} : {rd_lane[1], rd_lane[0]};

    // Align the returned word to the requested size; stores return zero.
    always_comb begin
        load_data = bus.mem_rdata;
        case (size_reg)
            2'b00:   load_data = {{24{sign_en & rd_byte[7]}}, rd_byte};
            2'b01:   load_data = {{16{sign_en & rd_half[15]}}, rd_half};
            default: load_data = bus.mem_rdata;
        endcase
        capture_data = we_reg ? '0 : load_data;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; DONE always returns to IDLE so the access is not re-issued.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (op) state_next = misaligned ? DONE : BUSY;
            BUSY:    if (bus.mem_ack || timed_out) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Stall output: the request cycle and every BUSY cycle hold the pipeline.
    always_comb begin
        stall_raw = 1'b0;
        case (state_reg)
            IDLE:    stall_raw = op;
            BUSY:    stall_raw = 1'b1;
            default: stall_raw = 1'b0;
        endcase
    end

    // Reset releases the pipeline immediately, even while an op is presented.
    assign StallMem = reset & stall_raw;

    // Bus command, timeout counter, load capture and fault pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_reg       <= 1'b0;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            be_reg        <= '0;
            wdata_reg     <= '0;
            offs_reg      <= '0;
            size_reg      <= '0;
            signed_reg    <= 1'b0;
            cnt_reg       <= '0;
            read_data_reg <= '0;
            fault_reg     <= 1'b0;
        end else begin
            fault_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (op) begin
                        if (misaligned) begin
                            fault_reg     <= 1'b1;
                            read_data_reg <= '0;
                        end else begin
                            req_reg    <= 1'b1;
                            we_reg     <= MemWriteM;
                            addr_reg   <= {ALUOutM[ADDR_W-1:2], 2'b00};
                            be_reg     <= be_next;
                            wdata_reg  <= wdata_next;
                            offs_reg   <= ALUOutM[1:0];
                            size_reg   <= SizeM;
                            signed_reg <= SignedM;
                            cnt_reg    <= '0;
                        end
                    end
                end
                BUSY: begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    // An ack in the timeout cycle still counts as success.
                    if (bus.mem_ack) begin
                        req_reg       <= 1'b0;
                        read_data_reg <= capture_data;
                    end else if (timed_out) begin
                        req_reg       <= 1'b0;
                        fault_reg     <= 1'b1;
                        read_data_reg <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_req   = req_reg;
    assign bus.mem_we    = we_reg;
    assign bus.mem_addr  = addr_reg;
    assign bus.mem_be    = be_reg;
    assign bus.mem_wdata = wdata_reg;
    assign ReadDataM     = read_data_reg;
    assign FaultM        = fault_reg;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: each access pushes its expected outcome
// to a scoreboard queue, the bench acts as the memory, and the entry is
// popped and compared when the unit reaches its completion cycle.
module tb_lsu_mem_stage;

    logic        clk;
    logic        reset;
    logic        MemReadM, MemWriteM, SignedM;
    logic [1:0]  SizeM;
    logic [31:0] ALUOutM, WriteDataM, ReadDataM;
    logic        StallMem, FaultM;

    int vectors     = 0;
    int miscompares = 0;

    lsu_mem_stage_if bus_if ();

    lsu_mem_stage dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .SizeM      (SizeM),
        .SignedM    (SignedM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallMem   (StallMem),
        .FaultM     (FaultM),
        .bus        (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef LSU_SIGNEXT_EN
    localparam logic [31:0] EXP_SB = 32'hFFFFFF80;
    localparam logic [31:0] EXP_SH = 32'hFFFF8001;
`else
    localparam logic [31:0] EXP_SB = 32'h00000080;
    localparam logic [31:0] EXP_SH = 32'h00008001;
`endif

    typedef struct {
        string       tag;
        int          stall;
        int          reqc;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rd;
        int          fault;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drop_op();
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        SizeM      = 2'b00;
        SignedM    = 1'b0;
        ALUOutM    = '0;
        WriteDataM = '0;
    endtask

    // Called at posedge+1. ack_at = n acks in the n-th cycle mem_req is seen
    // (0 = never). Leaves the bench at posedge+1 of the cycle after DONE.
    task automatic access(
        input string tag, input logic rd, input logic wr, input logic [1:0] sz,
        input logic sg, input logic [31:0] ad, input logic [31:0] wd,
        input int ack_at, input logic [31:0] rdata,
        input int e_stall, input int e_reqc, input logic [31:0] e_addr,
        input logic [3:0] e_be, input logic e_we, input logic [31:0] e_wdata,
        input logic [31:0] e_rd, input int e_fault);
        exp_t        e;
        int          stall, reqc, faults;
        bit          done;
        logic [31:0] c_addr, c_wdata, got_rd;
        logic [3:0]  c_be;
        logic        c_we;

        e = '{tag, e_stall, e_reqc, e_addr, e_be, e_we, e_wdata, e_rd, e_fault};
        sb.push_back(e);

        MemReadM = rd; MemWriteM = wr; SizeM = sz; SignedM = sg;
        ALUOutM = ad; WriteDataM = wd;

        stall = 0; reqc = 0; faults = 0; done = 1'b0;
        c_addr = '0; c_wdata = '0; c_be = '0; c_we = 1'b0; got_rd = '0;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            #1;
            if (bus_if.mem_req === 1'b1) begin
                reqc++;
                if (reqc == 1) begin
                    c_addr = bus_if.mem_addr; c_be = bus_if.mem_be;
                    c_we = bus_if.mem_we; c_wdata = bus_if.mem_wdata;
                end
                if (reqc == ack_at) begin
                    bus_if.mem_ack = 1'b1;
                    bus_if.mem_rdata = rdata;
                end
            end
            if (FaultM === 1'b1) faults++;
            if (StallMem === 1'b1) begin
                stall++;
            end else begin
                done = 1'b1;
                got_rd = ReadDataM;
                drop_op();
            end
            @(posedge clk); #1;
            bus_if.mem_ack = 1'b0;
            bus_if.mem_rdata = '0;
        end
        if (!done) chk({tag, "_cycle_bound"}, 32'd0, 32'd1);

        e = sb.pop_front();
        chk({e.tag, "_stall_cycles"}, stall, e.stall);
        chk({e.tag, "_req_cycles"},   reqc,  e.reqc);
        chk({e.tag, "_fault_pulses"}, faults, e.fault);
        chk({e.tag, "_rdata_done"},   got_rd, e.rd);
        if (e.reqc > 0) begin
            chk({e.tag, "_addr"},  c_addr,  e.addr);
            chk({e.tag, "_be"},    c_be,    e.be);
            chk({e.tag, "_we"},    c_we,    e.we);
            chk({e.tag, "_wdata"}, c_wdata, e.wdata);
        end
        // Back in IDLE: fault was a single pulse, bus idle, result held.
        chk({e.tag, "_fault_after"}, FaultM, 1'b0);
        chk({e.tag, "_req_after"},   bus_if.mem_req, 1'b0);
        chk({e.tag, "_rdata_hold"},  ReadDataM, e.rd);
        $display("txn %-12s stall=%0d req=%0d fault=%0d ReadDataM=0x%08h",
                 e.tag, stall, reqc, faults, got_rd);
    endtask

    initial begin
        reset = 1'b0;
        drop_op();
        bus_if.mem_ack = 1'b0;
        bus_if.mem_rdata = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",    bus_if.mem_req,   1'b0);
        chk("rst_we",     bus_if.mem_we,    1'b0);
        chk("rst_addr",   bus_if.mem_addr,  32'h0);
        chk("rst_be",     bus_if.mem_be,    4'h0);
        chk("rst_wdata",  bus_if.mem_wdata, 32'h0);
        chk("rst_rdata",  ReadDataM,        32'h0);
        chk("rst_fault",  FaultM,           1'b0);
        chk("rst_stall",  StallMem,         1'b0);
        $display("txn reset        outputs checked");

        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        // A stray ack while idle must be ignored.
        bus_if.mem_ack = 1'b1;
        bus_if.mem_rdata = 32'h55555555;
        @(posedge clk); #1;
        bus_if.mem_ack = 1'b0;
        bus_if.mem_rdata = '0;
        chk("idle_ack_req",   bus_if.mem_req, 1'b0);
        chk("idle_ack_stall", StallMem,       1'b0);
        chk("idle_ack_rdata", ReadDataM,      32'h0);
        $display("txn idle_ack     ignored");

        //     tag           rd    wr    sz     sg    addr          wdata         ack rdata
        //     stall req addr          be       we    wdata         rd            fault
        access("ld_word",    1'b1, 1'b0, 2'b10, 1'b0, 32'h00000100, 32'h00000000, 3, 32'hDEADBEEF,
               4, 3, 32'h00000100, 4'b1111, 1'b0, 32'h00000000, 32'hDEADBEEF, 0);
        access("ld_misalign", 1'b1, 1'b0, 2'b10, 1'b0, 32'h00000102, 32'h00000000, 1, 32'h12345678,
               1, 0, 32'h0, 4'b0000, 1'b0, 32'h0, 32'h00000000, 1);
        access("st_byte",    1'b0, 1'b1, 2'b00, 1'b0, 32'h00000103, 32'h000000A5, 1, 32'h0,
               2, 1, 32'h00000100, 4'b1000, 1'b1, 32'hA5A5A5A5, 32'h00000000, 0);
        access("ld_sbyte",   1'b1, 1'b0, 2'b00, 1'b1, 32'h00000301, 32'h00000000, 1, 32'h00008000,
               2, 1, 32'h00000300, 4'b0010, 1'b0, 32'h00000000, EXP_SB, 0);
        access("ld_timeout", 1'b1, 1'b0, 2'b01, 1'b0, 32'h00000202, 32'h00000000, 0, 32'h0,
               17, 16, 32'h00000200, 4'b1100, 1'b0, 32'h00000000, 32'h00000000, 1);
        access("st_half",    1'b0, 1'b1, 2'b01, 1'b0, 32'h00000106, 32'h1234BEEF, 2, 32'h0,
               3, 2, 32'h00000104, 4'b1100, 1'b1, 32'hBEEFBEEF, 32'h00000000, 0);
        access("ld_shalf",   1'b1, 1'b0, 2'b01, 1'b1, 32'h00000302, 32'h00000000, 1, 32'h80010000,
               2, 1, 32'h00000300, 4'b1100, 1'b0, 32'h00000000, EXP_SH, 0);
        access("rd_and_wr",  1'b1, 1'b1, 2'b10, 1'b0, 32'h00000400, 32'hCAFEF00D, 1, 32'h11111111,
               2, 1, 32'h00000400, 4'b1111, 1'b1, 32'hCAFEF00D, 32'h00000000, 0);
        access("ld_ubyte",   1'b1, 1'b0, 2'b00, 1'b0, 32'h00000303, 32'h00000000, 1, 32'hF0000000,
               2, 1, 32'h00000300, 4'b1000, 1'b0, 32'h00000000, 32'h000000F0, 0);

        // Reset asserted while the memory is still busy.
        MemReadM = 1'b1; SizeM = 2'b10; ALUOutM = 32'h0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("rst_busy_req_pre", bus_if.mem_req, 1'b1);
        reset = 1'b0;
        #1;
        chk("rst_busy_req",   bus_if.mem_req, 1'b0);
        chk("rst_busy_stall", StallMem,       1'b0);
        chk("rst_busy_fault", FaultM,         1'b0);
        $display("txn rst_busy     abort checked");
        drop_op();
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_rel_stall", StallMem, 1'b0);
        chk("rst_rel_fault", FaultM,   1'b0);

        access("ld_after_rst", 1'b1, 1'b0, 2'b10, 1'b0, 32'h00000000, 32'h00000000, 1, 32'h12345678,
               2, 1, 32'h00000000, 4'b1111, 1'b0, 32'h00000000, 32'h12345678, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
